// File: rtl/pic_reg_resp_if.sv
// PIC register bus: read, writable-mask and write requests sharing one address,
// with registered read/mask data and a collision error pulse.
interface pic_reg_resp_if;
  logic        picm_rden;
  logic        picm_mken;
  logic        picm_wren;
  logic [31:0] picm_addr;
  logic [31:0] picm_wr_data;
  logic [31:0] picm_rd_data;
  logic        picm_err;

  modport master (
    output picm_rden, picm_mken, picm_wren, picm_addr, picm_wr_data,
    input  picm_rd_data, picm_err
  );

  modport slave (
    input  picm_rden, picm_mken, picm_wren, picm_addr, picm_wr_data,
    output picm_rd_data, picm_err
  );
endinterface

// File: rtl/pic_reg_resp.sv
// Platform interrupt controller: register file, per-source gateways (sync, level/edge,
// polarity) and a priority arbiter producing a registered claim id and priority.
`ifndef RV_PIC_BASE_ADDR
`define RV_PIC_BASE_ADDR 32'hf00c0000
`endif

module pic_reg_resp #(
  parameter int unsigned NUM_SRC       = 8,
  parameter logic [31:0] PIC_BASE_ADDR = `RV_PIC_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  pic_reg_resp_if.slave      bus,
  input  logic [NUM_SRC-1:0] extintsrc_req,
  output logic               mexintpend,
  output logic [7:0]         claimid,
  output logic [3:0]         pl
);

  logic [14:0] offset;
  logic [2:0]  page;
  logic [4:0]  id;
  logic        id_ok, cfg_ok, wr_ok;
  logic        unused_bits;

  assign offset      = bus.picm_addr[14:0] - PIC_BASE_ADDR[14:0];
  assign page        = offset[14:12];
  assign id          = offset[6:2];
  assign id_ok       = (offset[11:7] == 5'd0) && (id != 5'd0) && (32'(id) < NUM_SRC);
  assign cfg_ok      = (offset[11:2] == 10'd0);
  // A write colliding with a read or mask request is dropped.
  assign wr_ok       = bus.picm_wren && !bus.picm_rden && !bus.picm_mken;
  assign unused_bits = ^{bus.picm_addr[31:15], offset[1:0]};

  logic [3:0]         meipl_q [NUM_SRC];
  logic [NUM_SRC-1:0] meie_q, typ_q, pol_q, pend_q, pend_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, s, s_q;
  logic               rev_q;
  logic [31:0]        rd_q, rd_val, mask_val;
  logic               err_q;
  logic               mexintpend_q;
  logic [7:0]         claimid_q;
  logic [3:0]         pl_q;

  logic [NUM_SRC-1:0] pl_wr, ie_wr, gw_wr, clr_wr;
  logic [3:0]         sel_pl;
  logic               sel_ip, sel_ie, sel_typ, sel_pol, cfg_wr;

  always_comb begin
    sel_pl  = '0;
    sel_ip  = 1'b0;
    sel_ie  = 1'b0;
    sel_typ = 1'b0;
    sel_pol = 1'b0;
    pl_wr   = '0;
    ie_wr   = '0;
    gw_wr   = '0;
    clr_wr  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_ok && id == 5'(i)) begin
        sel_pl    = meipl_q[i];
        sel_ip    = pend_q[i];
        sel_ie    = meie_q[i];
        sel_typ   = typ_q[i];
        sel_pol   = pol_q[i];
        pl_wr[i]  = wr_ok && page == 3'd0;
        ie_wr[i]  = wr_ok && page == 3'd2;
        gw_wr[i]  = wr_ok && page == 3'd4;
        clr_wr[i] = wr_ok && page == 3'd5;
      end
    end
    cfg_wr = wr_ok && page == 3'd3 && cfg_ok;
  end

  always_comb begin
    rd_val   = '0;
    mask_val = '0;
    case (page)
      3'd0: if (id_ok) begin
        rd_val   = {28'd0, sel_pl};
        mask_val = 32'h0000_000f;
      end
      3'd1: if (id_ok) rd_val = {31'd0, sel_ip};
      3'd2: if (id_ok) begin
        rd_val   = {31'd0, sel_ie};
        mask_val = 32'h0000_0001;
      end
      3'd3: if (cfg_ok) begin
        rd_val   = {31'd0, rev_q};
        mask_val = 32'h0000_0001;
      end
      3'd4: if (id_ok) begin
        rd_val   = {30'd0, sel_typ, sel_pol};
        mask_val = 32'h0000_0003;
      end
      default: ;
    endcase
  end

  // Gateway: edge sources latch a rising s; a type change wipes the latch.
  assign s = sync2_q ^ pol_q;

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gw_wr[i] && (bus.picm_wr_data[1] != typ_q[i])) begin
        pend_d[i] = 1'b0;
      end else if (typ_q[i]) begin
        pend_d[i] = (s[i] && !s_q[i]) || (pend_q[i] && !clr_wr[i]);
      end else begin
        pend_d[i] = s[i];
      end
    end
  end

  logic       found;
  logic [4:0] best_id;
  logic [3:0] best_pl;

  // Strict comparisons keep the lowest id on ties; priority 0 never competes.
  always_comb begin
    found   = 1'b0;
    best_id = '0;
    best_pl = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pend_q[i] && meie_q[i] && meipl_q[i] != 4'd0) begin
        if (!found || (rev_q ? (meipl_q[i] < best_pl) : (meipl_q[i] > best_pl))) begin
          found   = 1'b1;
          best_id = 5'(i);
          best_pl = meipl_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) meipl_q[i] <= '0;
      meie_q       <= '0;
      typ_q        <= '0;
      pol_q        <= '0;
      pend_q       <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      s_q          <= '0;
      rev_q        <= 1'b0;
      rd_q         <= '0;
      err_q        <= 1'b0;
      mexintpend_q <= 1'b0;
      claimid_q    <= '0;
      pl_q         <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pl_wr[i]) meipl_q[i] <= bus.picm_wr_data[3:0];
        if (ie_wr[i]) meie_q[i] <= bus.picm_wr_data[0];
        if (gw_wr[i]) begin
          typ_q[i] <= bus.picm_wr_data[1];
          pol_q[i] <= bus.picm_wr_data[0];
        end
      end
      if (cfg_wr) rev_q <= bus.picm_wr_data[0];
      sync1_q <= extintsrc_req;
      sync2_q <= sync1_q;
      s_q     <= s;
      pend_q  <= pend_d;
      if (bus.picm_mken) begin
        rd_q <= mask_val;
      end else if (bus.picm_rden) begin
        rd_q <= rd_val;
      end
      err_q        <= bus.picm_wren && (bus.picm_rden || bus.picm_mken);
      mexintpend_q <= found;
      claimid_q    <= found ? {3'd0, best_id} : 8'd0;
      pl_q         <= found ? best_pl : 4'd0;
    end
  end

  assign bus.picm_rd_data = rd_q;
  assign bus.picm_err     = err_q;
  assign mexintpend       = mexintpend_q;
  assign claimid          = claimid_q;
  assign pl               = pl_q;

endmodule

// File: tb/tb_pic_reg_resp.sv
// Directed bench for pic_reg_resp: a table of bus cycles with expected read data and
// error pulse, then hand-written interrupt, arbitration and reset sequences.
module tb_pic_reg_resp;
  localparam int unsigned NumSrc = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NumSrc-1:0] extintsrc_req;
  logic              mexintpend;
  logic [7:0]        claimid;
  logic [3:0]        pl;
  int                n_vec = 0;
  int                n_bad = 0;

  pic_reg_resp_if bus ();

  pic_reg_resp #(.NUM_SRC(NumSrc)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .extintsrc_req (extintsrc_req),
    .mexintpend    (mexintpend),
    .claimid       (claimid),
    .pl            (pl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rden;
    logic        mken;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic rd, input logic mk, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    bus.picm_rden    = rd;
    bus.picm_mken    = mk;
    bus.picm_wren    = wr;
    bus.picm_addr    = addr;
    bus.picm_wr_data = data;
    cyc(1);
    bus.picm_rden = 1'b0;
    bus.picm_mken = 1'b0;
    bus.picm_wren = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b0, 1'b0, 1'b1, addr, data);
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b1, 1'b0, 1'b0, addr, 32'h0);
    chk(name, bus.picm_rd_data, exp);
  endtask

  task automatic chk_irq(input string name, input logic ep, input logic [7:0] eid,
                         input logic [3:0] epl);
    chk({name, ".pend"}, {31'd0, mexintpend}, {31'd0, ep});
    chk({name, ".id"}, {24'd0, claimid}, {24'd0, eid});
    chk({name, ".pl"}, {28'd0, pl}, {28'd0, epl});
  endtask

  initial begin
    // rden, mken, wren, addr, wdata, exp_rd, exp_err
    vecs.push_back('{1, 0, 0, 32'h000C, 32'h0, 32'h0, 0});
    vecs.push_back('{0, 0, 1, 32'h000C, 32'hFFFF_FFF5, 32'h0, 0});
    vecs.push_back('{1, 0, 0, 32'h000C, 32'h0, 32'h5, 0});
    vecs.push_back('{0, 1, 0, 32'h4008, 32'h0, 32'h3, 0});
    vecs.push_back('{0, 1, 0, 32'h5008, 32'h0, 32'h0, 0});
    vecs.push_back('{0, 1, 0, 32'h0004, 32'h0, 32'hF, 0});
    vecs.push_back('{0, 1, 0, 32'h2004, 32'h0, 32'h1, 0});
    vecs.push_back('{0, 1, 0, 32'h3000, 32'h0, 32'h1, 0});
    vecs.push_back('{0, 1, 0, 32'h1004, 32'h0, 32'h0, 0});
    vecs.push_back('{1, 1, 0, 32'h0004, 32'h0, 32'hF, 0});
    vecs.push_back('{0, 0, 1, 32'h2014, 32'h1, 32'hF, 0});
    vecs.push_back('{1, 0, 0, 32'h2014, 32'h0, 32'h1, 0});
    vecs.push_back('{0, 0, 1, 32'h4014, 32'hFE, 32'h1, 0});
    vecs.push_back('{1, 0, 0, 32'h4014, 32'h0, 32'h2, 0});
    vecs.push_back('{0, 0, 1, 32'h0000, 32'h7, 32'h2, 0});
    vecs.push_back('{1, 0, 0, 32'h0000, 32'h0, 32'h0, 0});
    vecs.push_back('{0, 0, 1, 32'h0020, 32'h9, 32'h0, 0});
    vecs.push_back('{1, 0, 0, 32'h000C, 32'h0, 32'h5, 0});
    vecs.push_back('{1, 0, 0, 32'h0020, 32'h0, 32'h0, 0});
    vecs.push_back('{1, 0, 0, 32'h000C, 32'h0, 32'h5, 0});
    vecs.push_back('{1, 0, 0, 32'h6000, 32'h0, 32'h0, 0});
    vecs.push_back('{0, 1, 0, 32'h0004, 32'h0, 32'hF, 0});
    vecs.push_back('{0, 1, 0, 32'h0084, 32'h0, 32'h0, 0});
    vecs.push_back('{0, 0, 1, 32'h3000, 32'hFFFF, 32'h0, 0});
    vecs.push_back('{1, 0, 0, 32'h3000, 32'h0, 32'h1, 0});
    vecs.push_back('{0, 0, 1, 32'h3000, 32'h0, 32'h1, 0});
    vecs.push_back('{1, 0, 0, 32'h3000, 32'h0, 32'h0, 0});
    vecs.push_back('{1, 0, 0, 32'h000C, 32'h0, 32'h5, 0});
    vecs.push_back('{1, 0, 0, 32'h5014, 32'h0, 32'h0, 0});
    vecs.push_back('{0, 0, 1, 32'h0004, 32'h6, 32'h0, 0});
    vecs.push_back('{1, 0, 1, 32'h0004, 32'h9, 32'h6, 1});
    vecs.push_back('{0, 0, 0, 32'h0000, 32'h0, 32'h6, 0});
    vecs.push_back('{1, 0, 0, 32'h0004, 32'h0, 32'h6, 0});
    vecs.push_back('{0, 0, 1, 32'h1004, 32'h1, 32'h6, 0});
    vecs.push_back('{1, 0, 0, 32'h1004, 32'h0, 32'h0, 0});
    vecs.push_back('{0, 1, 1, 32'h0008, 32'h5, 32'hF, 1});
    vecs.push_back('{1, 0, 0, 32'h0008, 32'h0, 32'h0, 0});

    rst              = 1'b1;
    extintsrc_req    = '0;
    bus.picm_rden    = 1'b0;
    bus.picm_mken    = 1'b0;
    bus.picm_wren    = 1'b0;
    bus.picm_addr    = '0;
    bus.picm_wr_data = '0;
    cyc(2);
    chk("reset.rd_data", bus.picm_rd_data, 32'h0);
    chk("reset.err", {31'd0, bus.picm_err}, 32'h0);
    chk_irq("reset", 1'b0, 8'd0, 4'd0);
    rst = 1'b0;
    cyc(1);

    foreach (vecs[i]) begin
      drive(vecs[i].rden, vecs[i].mken, vecs[i].wren, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d.rd", i), bus.picm_rd_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d.err", i), {31'd0, bus.picm_err}, {31'd0, vecs[i].exp_err});
    end
    chk_irq("idle", 1'b0, 8'd0, 4'd0);

    // Edge source id2: one-cycle pulse, claim after 4 cycles, held until cleared.
    wr(32'h4008, 32'h2);
    wr(32'h2008, 32'h1);
    wr(32'h0008, 32'h3);
    cyc(2);
    extintsrc_req[2] = 1'b1;
    cyc(1);
    extintsrc_req[2] = 1'b0;
    cyc(2);
    chk_irq("edge.t3", 1'b0, 8'd0, 4'd0);
    cyc(1);
    chk_irq("edge.t4", 1'b1, 8'd2, 4'd3);
    cyc(4);
    chk_irq("edge.held", 1'b1, 8'd2, 4'd3);
    wr(32'h5008, 32'h0);
    chk_irq("edge.clr1", 1'b1, 8'd2, 4'd3);
    cyc(1);
    chk_irq("edge.clr2", 1'b0, 8'd0, 4'd0);

    // Level sources 1 and 4, equal priority, then reverse-priority mode.
    wr(32'h0004, 32'h7);
    wr(32'h0010, 32'h7);
    wr(32'h2004, 32'h1);
    wr(32'h2010, 32'h1);
    extintsrc_req[1] = 1'b1;
    extintsrc_req[4] = 1'b1;
    cyc(3);
    chk_irq("level.t3", 1'b0, 8'd0, 4'd0);
    cyc(1);
    chk_irq("level.tie", 1'b1, 8'd1, 4'd7);
    rd("level.meip4", 32'h1010, 32'h1);
    wr(32'h0010, 32'h2);
    cyc(1);
    chk_irq("level.high", 1'b1, 8'd1, 4'd7);
    wr(32'h3000, 32'h1);
    cyc(1);
    chk_irq("rev.low", 1'b1, 8'd4, 4'd2);
    wr(32'h0004, 32'h2);
    cyc(1);
    chk_irq("rev.tie", 1'b1, 8'd1, 4'd2);

    // Level id5 pending, then reset wipes the outputs at once.
    wr(32'h4014, 32'h0);
    wr(32'h0014, 32'h1);
    extintsrc_req = '0;
    extintsrc_req[5] = 1'b1;
    cyc(5);
    chk_irq("id5", 1'b1, 8'd5, 4'd1);
    rst = 1'b1;
    #1;
    chk_irq("rst.async", 1'b0, 8'd0, 4'd0);
    chk("rst.rd_data", bus.picm_rd_data, 32'h0);
    cyc(1);
    rst = 1'b0;
    extintsrc_req = '0;
    cyc(1);
    rd("rst.meie5", 32'h2014, 32'h0);
    rd("rst.meipl3", 32'h000C, 32'h0);
    cyc(5);
    chk_irq("rst.after", 1'b0, 8'd0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
